// File: rtl/seq_det_ctrl.sv
// Word-level controller around the serial "00..01" detector: accepts a word,
// scans it MSB-first one bit per clock and returns a saturating hit count.
module seq_det_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 4,
    parameter bit KEEP_STATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             hit,
    output logic             busy
);

    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0]   LAST_IDX = BCW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_t;
    typedef enum logic [1:0] {S0, Z1, Z2, HIT}   det_t;

    ctrl_t            state, state_nx;
    det_t             det, det_nx, det_step;
    logic [WIDTH-1:0] shreg;
    logic [BCW-1:0]   bcnt;
    logic             accept;
    logic             shifting;
    logic             scan_bit;
    logic             det_enter_hit;

    // ---------------- controller FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)        state_nx = SHIFT;
            SHIFT:   if (bcnt == '0)    state_nx = DONE;
            DONE:    if (out_ready)     state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        accept    = in_valid && (state == IDLE);
        shifting  = (state == SHIFT);
        scan_bit  = shreg[WIDTH-1];
    end

    // ---------------- detector FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) det <= S0;
        else        det <= det_nx;
    end

    always_comb begin
        det_step = det;
        case (det)
            S0:  det_step = scan_bit ? S0  : Z1;
            Z1:  det_step = scan_bit ? S0  : Z2;
            Z2:  det_step = scan_bit ? HIT : Z2;
            HIT: det_step = S0;
        endcase
        det_nx = det;
        if (shifting)
            det_nx = det_step;
        else if (accept && !KEEP_STATE)
            det_nx = S0;
    end

    always_comb begin
        det_enter_hit = shifting && (det_step == HIT);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            bcnt  <= '0;
        end else if (accept) begin
            shreg <= in_data;
            bcnt  <= LAST_IDX;
        end else if (shifting) begin
            shreg <= shreg << 1;
            bcnt  <= bcnt - 1'b1;
        end
    end

    // Count and hit both update on the edge the detector enters HIT, so a
    // detection on the final bit is already in out_count when DONE begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_count <= '0;
            hit       <= 1'b0;
        end else begin
            hit <= det_enter_hit;
            if (accept)
                out_count <= '0;
            else if (det_enter_hit && (out_count != CNT_MAX))
                out_count <= out_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: three instances (default, KEEP_STATE=1,
// CNT_W=1) share stimulus; directed table plus random words vs. a stream model.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, hit_a, busy_a;
    logic [3:0] out_count_a;
    logic       in_ready_k, out_valid_k, hit_k, busy_k;
    logic [3:0] out_count_k;
    logic       in_ready_c, out_valid_c, hit_c, busy_c;
    logic [0:0] out_count_c;

    int checks   = 0;
    int failures = 0;

    // running stream state of the KEEP_STATE=1 model
    int zk = 0;
    bit ak = 1'b0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.WIDTH(8), .CNT_W(4), .KEEP_STATE(1'b0)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_count(out_count_a), .hit(hit_a), .busy(busy_a));

    seq_det_ctrl #(.WIDTH(8), .CNT_W(4), .KEEP_STATE(1'b1)) u_k (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_k),
        .in_data(in_data), .out_valid(out_valid_k), .out_ready(out_ready),
        .out_count(out_count_k), .hit(hit_k), .busy(busy_k));

    seq_det_ctrl #(.WIDTH(8), .CNT_W(1), .KEEP_STATE(1'b0)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
        .out_count(out_count_c), .hit(hit_c), .busy(busy_c));

    typedef struct {
        logic [7:0] data;
        int         hold;
        bit         junk;
        int         exp_a;
        int         exp_k;
        int         exp_c;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stream rule: a 1 is a detection when preceded by at least two zeros that
    // follow the last reset point; the bit right after a detection is discarded.
    task automatic scan(input logic [7:0] w, input int z_in, input bit a_in,
                        output int z_out, output bit a_out,
                        output logic [7:0] hv, output int n);
        int z;
        bit a;
        z = z_in; a = a_in; n = 0; hv = '0;
        for (int j = 0; j < 8; j++) begin
            if (a) begin
                a = 1'b0; z = 0;
            end else if (w[7-j] == 1'b0) begin
                z++;
            end else begin
                if (z >= 2) begin
                    n++; hv[j] = 1'b1; a = 1'b1;
                end
                z = 0;
            end
        end
        z_out = z; a_out = a;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ready_a"}, in_ready_a, 1);
        chk({name, "_ready_k"}, in_ready_k, 1);
        chk({name, "_ready_c"}, in_ready_c, 1);
        chk({name, "_valid_a"}, out_valid_a, 0);
        chk({name, "_busy_a"},  busy_a, 0);
        chk({name, "_busy_k"},  busy_k, 0);
        chk({name, "_hit_a"},   hit_a, 0);
        chk({name, "_hit_k"},   hit_k, 0);
    endtask

    // Applies one word; call at #1 after a rising edge with the DUTs in IDLE.
    task automatic run_word(input logic [7:0] d, input int hold, input bit junk,
                            input int ea, input int ek, input int ec);
        logic [7:0] hv_a, hv_k;
        int na, nk, zd, guard;
        bit ad;
        scan(d, 0, 1'b0, zd, ad, hv_a, na);
        scan(d, zk, ak, zk, ak, hv_k, nk);
        guard = 0;
        while (!in_ready_a && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        chk("wait_in_ready", int'(guard < 40), 1);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = junk;
        in_data  = ~d;
        for (int m = 0; m <= 8; m++) begin
            chk("shift_busy_a",   busy_a, 1);
            chk("shift_ready_k",  in_ready_k, 0);
            chk("hit_a", hit_a, (m >= 1) ? int'(hv_a[m-1]) : 0);
            chk("hit_k", hit_k, (m >= 1) ? int'(hv_k[m-1]) : 0);
            chk("hit_c", hit_c, (m >= 1) ? int'(hv_a[m-1]) : 0);
            chk("out_valid_a", out_valid_a, int'(m == 8));
            if (m < 8) begin
                @(posedge clk); #1;
            end
        end
        chk("count_a", out_count_a, ea);
        chk("count_k", out_count_k, ek);
        chk("count_c", out_count_c, ec);
        chk("model_a", ((na > 15) ? 15 : na), ea);
        chk("model_k", ((nk > 15) ? 15 : nk), ek);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid_a", out_valid_a, 1);
            chk("hold_ready_a", in_ready_a, 0);
            chk("hold_hit_k",   hit_k, 0);
            chk("hold_count_a", out_count_a, ea);
            chk("hold_count_k", out_count_k, ek);
            chk("hold_count_c", out_count_c, ec);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_idle("post");
    endtask

    task automatic reset_check(input string name);
        reset = 1'b0;
        #2;
        chk_idle(name);
        chk({name, "_valid_k"}, out_valid_k, 0);
        chk({name, "_count_a"}, out_count_a, 0);
        chk({name, "_count_k"}, out_count_k, 0);
        chk({name, "_count_c"}, out_count_c, 0);
        chk({name, "_hit_c"},   hit_c, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        zk = 0; ak = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        logic [7:0] w;
        logic [7:0] hv_a, hv_k;
        int na, nk, zd, zk2;
        bit ad, ak2;

        vecs[0] = '{8'b0010_0000, 0, 1'b0, 1, 1, 1};
        vecs[1] = '{8'b0010_0101, 0, 1'b1, 1, 1, 1};
        vecs[2] = '{8'hFF,        2, 1'b0, 0, 0, 0};
        vecs[3] = '{8'b0000_0001, 0, 1'b0, 1, 1, 1};
        vecs[4] = '{8'b1111_1100, 1, 1'b1, 0, 0, 0};
        vecs[5] = '{8'hFF,        0, 1'b0, 0, 1, 0};
        vecs[6] = '{8'b0010_0010, 5, 1'b1, 2, 2, 1};
        vecs[7] = '{8'h00,        0, 1'b0, 0, 0, 0};
        vecs[8] = '{8'b1000_0000, 3, 1'b0, 0, 1, 0};
        vecs[9] = '{8'b1001_0010, 0, 1'b1, 1, 2, 1};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset_count_a", out_count_a, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle("idle");

        for (int i = 0; i < 10; i++)
            run_word(vecs[i].data, vecs[i].hold, vecs[i].junk,
                     vecs[i].exp_a, vecs[i].exp_k, vecs[i].exp_c);

        // reset in the cycle the hit pulse is up, mid-SHIFT
        in_valid = 1'b1; in_data = 8'b0010_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_hit_a", hit_a, 1);
        reset_check("rst_shift");
        run_word(8'b0001_0000, 0, 1'b0, 1, 1, 1);

        // reset while DONE waits with a nonzero count
        in_valid = 1'b1; in_data = 8'b0000_0001; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_valid_a", out_valid_a, 1);
        chk("pre_reset_count_a", out_count_a, 1);
        reset_check("rst_done");

        for (int i = 0; i < 40; i++) begin
            w = 8'($urandom) & 8'($urandom);
            scan(w, 0, 1'b0, zd, ad, hv_a, na);
            scan(w, zk, ak, zk2, ak2, hv_k, nk);
            run_word(w, int'($urandom_range(0, 3)), 1'($urandom),
                     (na > 15) ? 15 : na, (nk > 15) ? 15 : nk, (na > 1) ? 1 : na);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
